// File: rtl/mem_resp_pkg.sv
// Shared constants and types for the memory-bus responder.
// Bus polarities follow the core: READ=1, strobes active low.
package mem_resp_pkg;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned WORD_DATA_W = 32;
    localparam int unsigned WAIT_CNT_W  = 4;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        MEM_RESP_IDLE = 2'b00,
        MEM_RESP_WAIT = 2'b01,
        MEM_RESP_ACK  = 2'b10
    } mem_resp_state_e;

    // Counter preload: the accept cycle itself counts as the first wait state.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? '0 : WAIT_CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous word RAM; the read register clears whenever no
// read is requested so its output can drive an OR-muxed bus directly.
module mem_resp_ram #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array storage is intentionally left without reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[idx];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/mem_resp.sv
// Memory-bus responder: accepts a strobed request, inserts WAIT_CYCLES wait
// states, then acknowledges with a one-cycle active-low rdy_.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = WORD_ADDR_W,
    parameter int unsigned DATA_W      = WORD_DATA_W,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  = wait_load(WAIT_CYCLES);
    localparam bit                    DIRECT_ACK = (WAIT_CYCLES == 0);

    mem_resp_state_e       state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_rw;
    logic [DATA_W-1:0]     req_data;

    logic                  req_c;
    logic                  wait_done_c;
    logic                  ram_re_c;
    logic                  ram_we_c;
    logic [DEPTH_LOG2-1:0] ram_idx_c;

    assign req_c       = (cs_ == ENABLE_) && (as_ == ENABLE_);
    assign wait_done_c = (wait_cnt == '0);

    // Upper address bits alias onto the RAM and are deliberately dropped.
    if (ADDR_W > DEPTH_LOG2) begin : g_alias
        logic unused_addr_c;
        assign unused_addr_c = ^addr[ADDR_W-1:DEPTH_LOG2];
    end

    // RAM port steering: read fires on the edge entering ACK, write on the
    // edge leaving it; the two never coincide on the single port.
    always_comb begin
        ram_re_c  = 1'b0;
        ram_we_c  = 1'b0;
        ram_idx_c = req_idx;
        case (state)
            MEM_RESP_IDLE: begin
                ram_idx_c = addr[DEPTH_LOG2-1:0];
                ram_re_c  = DIRECT_ACK && req_c && (rw == READ);
            end
            MEM_RESP_WAIT: begin
                ram_re_c = req_c && wait_done_c && (req_rw == READ);
            end
            MEM_RESP_ACK: begin
                ram_we_c = (req_rw == WRITE);
            end
            default: begin
                ram_re_c = 1'b0;
            end
        endcase
    end

    // Request FSM with registered ready strobe.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= MEM_RESP_IDLE;
            rdy_     <= DISABLE_;
            wait_cnt <= '0;
            req_idx  <= '0;
            req_rw   <= WRITE;
            req_data <= '0;
        end else begin
            rdy_ <= DISABLE_;
            case (state)
                MEM_RESP_IDLE: begin
                    if (req_c) begin
                        req_idx  <= addr[DEPTH_LOG2-1:0];
                        req_rw   <= rw;
                        req_data <= wr_data;
                        wait_cnt <= WAIT_LOAD;
                        if (DIRECT_ACK) begin
                            state <= MEM_RESP_ACK;
                            rdy_  <= ENABLE_;
                        end else begin
                            state <= MEM_RESP_WAIT;
                        end
                    end
                end
                MEM_RESP_WAIT: begin
                    if (!req_c) begin
                        state <= MEM_RESP_IDLE;
                    end else if (wait_done_c) begin
                        state <= MEM_RESP_ACK;
                        rdy_  <= ENABLE_;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                MEM_RESP_ACK: begin
                    state <= MEM_RESP_IDLE;
                end
                default: begin
                    state <= MEM_RESP_IDLE;
                end
            endcase
        end
    end

    mem_resp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .reset_  (reset_),
        .we      (ram_we_c),
        .re      (ram_re_c),
        .idx     (ram_idx_c),
        .wr_data (req_data),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: one instance with two wait states and one
// with none, driven by directed and randomized bus transactions.
module tb_mem_resp;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef struct {
        int          inst;
        logic        rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        t_rst  [2];
    logic        t_cs   [2];
    logic        t_as   [2];
    logic        t_rw   [2];
    logic [29:0] t_addr [2];
    logic [31:0] t_wd   [2];
    logic [31:0] o_rd   [2];
    logic        o_rdy  [2];

    exp_t        sb [$];
    logic [31:0] mm [2][1024];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_resp #(.ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_slow (
        .clk(clk), .reset_(t_rst[0]), .cs_(t_cs[0]), .as_(t_as[0]), .rw(t_rw[0]),
        .addr(t_addr[0]), .wr_data(t_wd[0]), .rd_data(o_rd[0]), .rdy_(o_rdy[0])
    );

    mem_resp #(.ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .reset_(t_rst[1]), .cs_(t_cs[1]), .as_(t_as[1]), .rw(t_rw[1]),
        .addr(t_addr[1]), .wr_data(t_wd[1]), .rd_data(o_rd[1]), .rdy_(o_rdy[1])
    );

    function automatic int wcyc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic void chk(input string name, input int inst,
                                input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d: got %h expected %h", name, inst, cyc, act, exp);
        end
    endfunction

    function automatic logic [9:0] pool_idx(input int k);
        case (k)
            0:       return 10'h005;
            1:       return 10'h007;
            2:       return 10'h001;
            3:       return 10'h003;
            4:       return 10'h3FF;
            5:       return 10'h000;
            6:       return 10'h200;
            default: return 10'h0AA;
        endcase
    endfunction

    function automatic logic [29:0] mk_addr(input logic [9:0] idx);
        logic [29:0] a;
        a       = 30'($urandom);
        a[9:0]  = idx;
        return a;
    endfunction

    // Monitor: every rdy_ pulse must match the oldest expectation; otherwise
    // the bus must be quiet.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (o_rdy[i] === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("spurious_rdy", i, {31'd0, o_rdy[i]}, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("ack_inst", i, 32'(i), 32'(e.inst));
                    chk("ack_cycle", i, 32'(cyc), 32'(e.cyc));
                    chk(e.rd ? "read_data" : "write_rd_data", i, o_rd[i], e.data);
                end
            end else begin
                chk("rdy_idle", i, {31'd0, o_rdy[i]}, 32'd1);
                chk("rd_data_idle", i, o_rd[i], 32'd0);
            end
        end
    end

    task automatic drive(input int i, input logic cs, input logic as, input logic r,
                         input logic [29:0] a, input logic [31:0] d);
        t_cs[i]   = cs;
        t_as[i]   = as;
        t_rw[i]   = r;
        t_addr[i] = a;
        t_wd[i]   = d;
    endtask

    task automatic release_bus(input int i);
        t_cs[i] = 1'b1;
        t_as[i] = 1'b1;
    endtask

    // One transaction. chain: continue from the ACK-cycle negedge with as_ still
    // low. keep: leave as_ low after rdy_. abort_at>0: drop as_ that many
    // cycles after the accept cycle, expecting no acknowledge.
    task automatic txn(input int i, input logic r, input logic [29:0] a, input logic [31:0] d,
                       input bit chain, input bit keep, input int abort_at);
        int   acc;
        exp_t e;
        bit   seen;
        if (!chain) @(negedge clk);
        drive(i, 1'b0, 1'b0, r, a, d);
        acc = chain ? cyc + 1 : cyc;
        if (abort_at > 0) begin
            while (cyc < acc + abort_at) @(negedge clk);
            release_bus(i);
            repeat (3) @(negedge clk);
            return;
        end
        e.inst = i;
        e.rd   = r;
        e.cyc  = acc + wcyc(i) + 1;
        e.data = r ? mm[i][a[9:0]] : 32'd0;
        if (!r) mm[i][a[9:0]] = d;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            seen = (o_rdy[i] === 1'b0);
        end
        chk("ack_seen", i, 32'(seen), 32'd1);
        if (!seen || !keep) release_bus(i);
    endtask

    task automatic rand_phase(input int i, input int n);
        bit          prev_keep;
        bit          keep;
        int          kind;
        logic        r;
        logic [29:0] a;
        logic [31:0] d;
        prev_keep = 1'b0;
        for (int k = 0; k < 8; k++) txn(i, WR, mk_addr(pool_idx(k)), $urandom, 1'b0, 1'b0, 0);
        for (int t = 0; t < n; t++) begin
            kind = $urandom_range(0, 19);
            r    = 1'($urandom_range(0, 1));
            a    = mk_addr(pool_idx($urandom_range(0, 7)));
            d    = $urandom;
            if (kind == 0 && !prev_keep) begin
                @(negedge clk);
                drive(i, 1'b1, 1'b0, r, a, d);
                repeat (3) @(negedge clk);
                release_bus(i);
                @(negedge clk);
            end else if (kind < 4 && wcyc(i) > 0) begin
                txn(i, r, a, d, prev_keep, 1'b0, $urandom_range(1, wcyc(i)));
                prev_keep = 1'b0;
            end else begin
                keep = 1'($urandom_range(0, 1));
                txn(i, r, a, d, prev_keep, keep, 0);
                prev_keep = keep;
            end
        end
        if (prev_keep) begin
            release_bus(i);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            t_rst[i] = 1'b0;
            drive(i, 1'b1, 1'b1, RD, 30'd0, 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("reset_rdy", 0, {31'd0, o_rdy[0]}, 32'd1);
        chk("reset_rd_data", 0, o_rd[0], 32'd0);
        t_rst[0] = 1'b1;
        t_rst[1] = 1'b1;

        // Deselected bus stays quiet.
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_rdy", 0, {31'd0, o_rdy[0]}, 32'd1);
        end

        // Two-wait-state write then read-back.
        txn(0, WR, 30'h5, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        txn(0, RD, 30'h5, 32'd0,        1'b0, 1'b0, 0);

        // Aborted writes leave the old value.
        txn(0, WR, 30'h7, 32'h1111_2222, 1'b0, 1'b0, 0);
        txn(0, WR, 30'h7, 32'hAAAA_AAAA, 1'b0, 1'b0, 1);
        txn(0, WR, 30'h7, 32'hAAAA_AAAA, 1'b0, 1'b0, 2);
        txn(0, RD, 30'h7, 32'd0,         1'b0, 1'b0, 0);

        // Reset in the middle of a write's wait states drops it.
        @(negedge clk);
        drive(0, 1'b0, 1'b0, WR, 30'h5, 32'h0BAD_F00D);
        @(negedge clk);
        #1 t_rst[0] = 1'b0;
        release_bus(0);
        #1 chk("reset_wait_rdy", 0, {31'd0, o_rdy[0]}, 32'd1);
        #1 t_rst[0] = 1'b1;
        txn(0, RD, 30'h5, 32'd0, 1'b0, 1'b0, 0);

        // Reset during a read acknowledge clears the bus without a clock.
        txn(0, RD, 30'h5, 32'd0, 1'b0, 1'b1, 0);
        #1 t_rst[0] = 1'b0;
        release_bus(0);
        #1 chk("reset_ack_rdy", 0, {31'd0, o_rdy[0]}, 32'd1);
        chk("reset_ack_rd_data", 0, o_rd[0], 32'd0);
        #1 t_rst[0] = 1'b1;

        // Address aliasing above the RAM depth.
        txn(0, WR, 30'h403, 32'h55, 1'b0, 1'b0, 0);
        txn(0, RD, 30'h003, 32'd0,  1'b0, 1'b0, 0);

        // Zero-wait instance: alternating write/read with as_ held low.
        txn(1, WR, 30'h1, 32'h1234_5678, 1'b0, 1'b1, 0);
        for (int k = 0; k < 4; k++) begin
            txn(1, RD, 30'h1, 32'd0,    1'b1, 1'b1, 0);
            txn(1, WR, 30'h1, $urandom, 1'b1, 1'b1, 0);
        end
        txn(1, RD, 30'h1,   32'd0, 1'b1, 1'b0, 0);
        txn(1, WR, 30'h403, 32'h55, 1'b0, 1'b0, 0);
        txn(1, RD, 30'h003, 32'd0,  1'b0, 1'b0, 0);

        rand_phase(0, 150);
        rand_phase(1, 150);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
